// File: rtl/rd_fwft_stage.sv
// rd_fwft_stage
// Read-side first-word-fall-through output stage of the asynchronous FIFO.
// Converts the FIFO empty flag / increment strobe into a valid/ready stream.
// A two-entry registered buffer (head + skid) lets the fetch decision depend
// only on local state, so out_ready never reaches the read pointers
// combinationally while one word per cycle is still sustained.

module rd_fwft_stage #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 rd_clk,
    input  logic                 rd_rstn,
    input  logic                 rd_empty,
    input  logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_inc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [1:0]           out_count
);

    // Occupancy of the stage; the encoding is the word count itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } cnt_state_t;

    cnt_state_t             cnt_r;
    cnt_state_t             cnt_nx_s;
    logic [DATA_SIZE-1:0]   head_r;
    logic [DATA_SIZE-1:0]   head_nx_s;
    logic [DATA_SIZE-1:0]   skid_r;
    logic [DATA_SIZE-1:0]   skid_nx_s;
    logic                   valid_r;
    logic                   valid_nx_s;
    logic                   push_s;
    logic                   pop_s;

    // Fetch and accept strobes. The fetch uses only registered state and the
    // registered empty flag; the unreachable count of 3 never fetches.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (!rd_empty && ((cnt_r == ST_EMPTY) || (cnt_r == ST_ONE))) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (valid_r && out_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next-state and next-data selection for the two-entry buffer.
    always_comb begin
        cnt_nx_s  = cnt_r;
        head_nx_s = head_r;
        skid_nx_s = skid_r;
        case (cnt_r)
            ST_EMPTY: begin
                if (push_s) begin
                    head_nx_s = rd_data;
                    cnt_nx_s  = ST_ONE;
                end else begin
                    cnt_nx_s  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && pop_s) begin
                    head_nx_s = rd_data;
                    cnt_nx_s  = ST_ONE;
                end else if (push_s) begin
                    skid_nx_s = rd_data;
                    cnt_nx_s  = ST_TWO;
                end else if (pop_s) begin
                    cnt_nx_s  = ST_EMPTY;
                end else begin
                    cnt_nx_s  = ST_ONE;
                end
            end
            ST_TWO: begin
                // No fetch is issued in this state, so only a pop can move it.
                if (pop_s) begin
                    head_nx_s = skid_r;
                    cnt_nx_s  = ST_ONE;
                end else begin
                    cnt_nx_s  = ST_TWO;
                end
            end
            default: begin
                // Corrupted state: recover to empty and drop contents.
                cnt_nx_s  = ST_EMPTY;
                head_nx_s = {DATA_SIZE{1'b0}};
                skid_nx_s = {DATA_SIZE{1'b0}};
            end
        endcase
        if (cnt_nx_s != ST_EMPTY) begin
            valid_nx_s = 1'b1;
        end else begin
            valid_nx_s = 1'b0;
        end
    end

    // State and data registers; reset discards any buffered words.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            cnt_r   <= ST_EMPTY;
            head_r  <= {DATA_SIZE{1'b0}};
            skid_r  <= {DATA_SIZE{1'b0}};
            valid_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nx_s;
            head_r  <= head_nx_s;
            skid_r  <= skid_nx_s;
            valid_r <= valid_nx_s;
        end
    end

    assign rd_inc    = push_s;
    assign out_valid = valid_r;
    assign out_data  = head_r;
    assign out_count = cnt_r;

endmodule

// File: doc/rd_fwft_stage.md
# rd_fwft_stage

Read-side output stage of the asynchronous FIFO. It sits directly downstream of the read-pointer/empty logic and the dual-port memory read port, all in the read clock domain. It turns the FIFO's empty flag and increment strobe into a first-word-fall-through valid/ready stream. It has a two-entry registered buffer, so the consumer's `out_ready` never combinationally reaches the FIFO pointers, and full throughput is sustained.

## Interface
- `DATA_SIZE`, default 8: width of a FIFO word.
- `rd_clk`  in  1: read-domain clock. All state changes on its rising edge.
- `rd_rstn`  in  1: reset, asynchronous, active-low.
- `rd_empty`  in  1: registered empty flag from the read-pointer block. It is 1 out of reset.
- `rd_data`  in  DATA_SIZE: memory read data.
  - Combinational from the current read address.
  - Valid in any cycle where `rd_empty` = 0.
- `rd_inc`  out  1: read-increment strobe to the read-pointer block.
  - Combinational.
  - Pops the word currently on `rd_data` at the next edge.
- `out_valid`  out  1: the head word is available on `out_data`.
- `out_ready`  in  1: the consumer accepts the head word this cycle.
- `out_data`  out  DATA_SIZE: head word. Registered.
- `out_count`  out  2: number of words held in the stage (0..2). Registered.

## Operation
- Storage is two registers:
  - `head` drives `out_data`.
  - `skid` holds the second word.
- The count register `cnt` uses states EMPTY (0), ONE (1) and TWO (2). `out_count` = `cnt`, and `out_valid` = (`cnt` != 0).
- Fetch rule: `rd_inc` = ~`rd_empty` & (`cnt` < 2).
  - `rd_inc` depends only on registered signals, never on `out_ready`.
  - Whenever `rd_inc` = 1, capture `rd_data` in that same cycle.
- Pop: `pop` = `out_valid` & `out_ready`. `out_ready` while `out_valid` = 0 is ignored.
- Transitions (`push` = `rd_inc`):
  - EMPTY, push: `head` ← `rd_data`, go to ONE.
  - EMPTY, no push: stay in EMPTY. `head` holds its last value.
  - ONE, push & pop: `head` ← `rd_data`, stay in ONE.
  - ONE, push, no pop: `skid` ← `rd_data`, go to TWO.
  - ONE, pop, no push: go to EMPTY.
  - ONE, neither: hold.
  - TWO, pop: `head` ← `skid`, go to ONE. No push is possible in TWO.
  - TWO, no pop: hold. `out_data` stays stable while `out_valid` = 1 and `out_ready` = 0.
- Ordering: words leave in exactly the FIFO order. No word is dropped or duplicated.
- `cnt` never exceeds 2 and never underflows. There is no reachable state with `cnt` = 3.
- Reset, asynchronous (including mid-operation):
  - `cnt`, `out_count`, `head` and `skid` clear to 0, so `out_valid` = 0 and `out_data` = 0.
  - Buffered words are discarded. The pointer block resets on the same signal.
  - `rd_inc` = 0 during reset because `rd_empty` = 1.
- On reset release, the first fetch can occur only after the pointer block deasserts `rd_empty`.

## Timing
- Fall-through latency: if `rd_empty` = 0 at cycle N with `cnt` < 2, `rd_inc` = 1 at N and the word is on `out_data` with `out_valid` = 1 at N+1.
- Steady-state throughput with `out_ready` held at 1 and the FIFO non-empty: `cnt` stays 1, with one word per cycle both in and out.
- Backpressure:
  - `out_ready` = 0 with the FIFO non-empty fills to TWO within 2 cycles, after which `rd_inc` = 0.
  - Raising `out_ready` at cycle M pops at M. `rd_inc` resumes at M+1 (`cnt` is 1 by then).
- Empty boundary: when `rd_empty` rises, `rd_inc` drops in the same cycle. The buffered words still drain normally.
- Simultaneous push and pop in ONE keep `out_valid` continuously 1 with no bubble.

## Test plan
- Reset: assert `rd_rstn` = 0 while `cnt` = 2.
  - Required: `out_valid` = 0, `out_count` = 0 and `out_data` = 0 immediately, asynchronously.
  - Required: `rd_inc` = 0 until `rd_empty` = 0.
- Single word: `rd_empty` = 0 for one word 0xA5 with `out_ready` = 1.
  - Required: `rd_inc` pulses 1 cycle.
  - Required: next cycle `out_valid` = 1 and `out_data` = 0xA5, then `out_valid` = 0.
- Streaming: 16 words 0x00..0x0F with `out_ready` = 1.
  - Required: 16 consecutive `out_valid` cycles in order, `out_count` = 1 throughout, no gaps.
- Backpressure: 8 words available, `out_ready` = 0 for 5 cycles, then 1.
  - Required: `rd_inc` asserts for exactly 2 cycles, then `out_count` = 2 and `out_data` holds word 0 stable.
  - Required: after release, all 8 words arrive in order.
- Random: random `out_ready` (50%) and random FIFO fill over 1000 words.
  - Required: scoreboard order is exact.
  - Required: `out_count` never exceeds 2, and there is never a pop with `out_valid` = 0.
- Drain at empty: 3 words, `rd_empty` rises while `cnt` = 2.
  - Required: `rd_inc` = 0.
  - Required: the remaining 2 words are delivered on the next 2 `out_ready` cycles, then `out_valid` = 0.
